// File: rtl/eecd_pkg.sv
// Shared definitions for the row-packet producer: packet types, pattern constants,
// beat field positions, FSM state encoding and the per-word pattern helper.
package eecd_pkg;

    localparam int unsigned AXIS_DATA_W = 512;
    localparam int unsigned AXI_REQ_W   = 72;

    localparam logic [7:0] PKT_TYPE_ROW = 8'd0;
    localparam logic [7:0] PKT_TYPE_AXI = 8'd1;

    localparam logic [31:0] P0 = 32'h0000_0000;
    localparam logic [31:0] P1 = 32'hFFFF_FFFF;
    localparam logic [31:0] P2 = 32'hAAAA_AAAA;
    localparam logic [31:0] P3 = 32'h5555_5555;

    localparam int unsigned PKT_TYPE_LSB   = 504;
    localparam int unsigned PKT_TYPE_W     = 8;
    localparam int unsigned ROW_IDX_LSB    = 0;
    localparam int unsigned ROW_IDX_W      = 64;
    localparam int unsigned ADDR_LSB       = 0;
    localparam int unsigned DATA_LSB       = 32;
    localparam int unsigned FIELD_W        = 32;
    localparam int unsigned MODE_BIT       = 64;
    localparam int unsigned ERR_INJECT_BIT = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_TRL,
        ST_BOUNDARY,
        ST_REQ
    } state_e;

    function automatic logic [31:0] pattern_word(input logic [31:0] seed, input int unsigned k);
        logic [1:0]  sel;
        logic [31:0] pat;
        sel = k[1:0];
        case (sel)
            2'd0:    pat = P0;
            2'd1:    pat = P1;
            2'd2:    pat = P2;
            default: pat = P3;
        endcase
        return seed ^ pat;
    endfunction

endpackage

// File: rtl/row_pattern_gen.sv
// Combinational integrity-pattern generator: expands a 32-bit seed into one
// 512-bit row-data beat (word k = seed ^ P[k % 4]).
module row_pattern_gen
    import eecd_pkg::*;
(
    input  logic [31:0]            seed_i,
    output logic [AXIS_DATA_W-1:0] beat_o
);

    always_comb begin
        beat_o = '0;
        for (int unsigned k = 0; k < AXIS_DATA_W / 32; k++) begin
            beat_o[32*k +: 32] = pattern_word(seed_i, k);
        end
    end

endmodule

// File: rtl/axis_row_producer.sv
// Row-packet producer: header / DATA_CYCLES pattern beats / trailer per row, with AXI
// request beats inserted only between rows. Optional macro AXIS_ROW_PRODUCER_ERROR_INJECT_EN.
module axis_row_producer
    import eecd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 512,
    parameter int unsigned DATA_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef AXIS_ROW_PRODUCER_ERROR_INJECT_EN
    input  logic                  inject_error,
`endif
    input  logic                  start,
    input  logic [63:0]           row_count,
    output logic                  busy,
    output logic                  done,
    output logic [63:0]           rows_sent,
    output logic [DATA_WIDTH-1:0] AXIS_OUT_TDATA,
    output logic                  AXIS_OUT_TVALID,
    input  logic                  AXIS_OUT_TREADY,
    input  logic [AXI_REQ_W-1:0]  AXI_REQ_IN_TDATA,
    input  logic                  AXI_REQ_IN_TVALID,
    output logic                  AXI_REQ_IN_TREADY
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [63:0]           rows_sent_q, rows_sent_d;
    logic [63:0]           row_count_q, row_count_d;
    logic [31:0]           seed_q, seed_d;
    logic [7:0]            beat_q, beat_d;
    logic                  req_tready_q, req_tready_d;
    logic                  err_armed_q, err_armed_d;

    logic                  inject_now;
    logic                  out_hs, req_cap, at_boundary, beat_last, rows_done, fresh;
    logic [DATA_WIDTH-1:0] pat_beat;
    logic [6:0]            unused_req_bits;

`ifdef AXIS_ROW_PRODUCER_ERROR_INJECT_EN
    assign inject_now = inject_error;
`else
    assign inject_now = 1'b0;
`endif

    assign unused_req_bits = AXI_REQ_IN_TDATA[AXI_REQ_W-1:MODE_BIT+1];

    assign out_hs      = tvalid_q & AXIS_OUT_TREADY;
    assign at_boundary = (state_q == ST_IDLE) || (state_q == ST_BOUNDARY);
    assign req_cap     = at_boundary & req_tready_q & AXI_REQ_IN_TVALID;
    assign beat_last   = (beat_q == 8'(DATA_CYCLES - 1));
    assign rows_done   = (rows_sent_q == row_count_q);

    row_pattern_gen u_pattern (
        .seed_i (seed_d),
        .beat_o (pat_beat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rows_sent_q  <= '0;
            row_count_q  <= '0;
            seed_q       <= '0;
            beat_q       <= '0;
            req_tready_q <= 1'b0;
            err_armed_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rows_sent_q  <= rows_sent_d;
            row_count_q  <= row_count_d;
            seed_q       <= seed_d;
            beat_q       <= beat_d;
            req_tready_q <= req_tready_d;
            err_armed_q  <= err_armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_cap)                         state_d = ST_REQ;
                else if (start && row_count != '0)   state_d = ST_HDR;
            end
            ST_HDR:  if (out_hs)              state_d = ST_DATA;
            ST_DATA: if (out_hs && beat_last) state_d = ST_TRL;
            ST_TRL:  if (out_hs)              state_d = ST_BOUNDARY;
            ST_BOUNDARY: begin
                if (req_cap)        state_d = ST_REQ;
                else if (rows_done) state_d = ST_IDLE;
                else                state_d = ST_HDR;
            end
            // The boundary decision is folded into the request handshake so a request
            // that wins against start delays the first header by exactly one beat.
            ST_REQ: if (out_hs) state_d = (busy_q && !rows_done) ? ST_HDR : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        row_count_d = row_count_q;
        rows_sent_d = rows_sent_q;
        seed_d      = seed_q;
        beat_d      = beat_q;
        if (state_q == ST_IDLE && start) begin
            row_count_d = row_count;
            rows_sent_d = '0;
            seed_d      = '0;
            beat_d      = '0;
        end
        if (state_q == ST_DATA && out_hs) begin
            seed_d = seed_q + 32'd1;
            beat_d = beat_last ? 8'd0 : beat_q + 8'd1;
        end
        if (state_q == ST_TRL && out_hs) begin
            rows_sent_d = rows_sent_q + 64'd1;
        end
    end

    always_comb begin
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_armed_d  = err_armed_q | inject_now;
        req_tready_d = (state_d == ST_IDLE) || (state_d == ST_BOUNDARY);

        if (state_q == ST_IDLE && start) begin
            if (row_count != '0) busy_d = 1'b1;
            else                 done_d = 1'b1;
        end
        if ((state_q == ST_BOUNDARY && !req_cap && rows_done) ||
            (state_q == ST_REQ && out_hs && busy_q && rows_done)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end

        // A new beat is loaded whenever the held one is consumed or none is on the bus.
        fresh = at_boundary || out_hs;
        if (fresh) begin
            tdata_d  = '0;
            tvalid_d = 1'b1;
            case (state_d)
                ST_HDR, ST_TRL: begin
                    tdata_d[PKT_TYPE_LSB +: PKT_TYPE_W] = PKT_TYPE_ROW;
                    tdata_d[ROW_IDX_LSB +: ROW_IDX_W]   = rows_sent_d;
                end
                ST_DATA: begin
                    tdata_d = pat_beat;
                    if (err_armed_q || inject_now) begin
                        tdata_d[ERR_INJECT_BIT] = ~pat_beat[ERR_INJECT_BIT];
                        err_armed_d             = 1'b0;
                    end
                end
                ST_REQ: begin
                    tdata_d[PKT_TYPE_LSB +: PKT_TYPE_W] = PKT_TYPE_AXI;
                    tdata_d[ADDR_LSB +: FIELD_W]        = AXI_REQ_IN_TDATA[ADDR_LSB +: FIELD_W];
                    tdata_d[DATA_LSB +: FIELD_W]        = AXI_REQ_IN_TDATA[DATA_LSB +: FIELD_W];
                    tdata_d[MODE_BIT]                   = AXI_REQ_IN_TDATA[MODE_BIT];
                end
                default: tvalid_d = 1'b0;
            endcase
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign rows_sent         = rows_sent_q;
    assign AXIS_OUT_TDATA    = tdata_q;
    assign AXIS_OUT_TVALID   = tvalid_q;
    assign AXI_REQ_IN_TREADY = req_tready_q;

endmodule

// File: tb/tb_axis_row_producer.sv
// Directed bench for axis_row_producer; honours AXIS_ROW_PRODUCER_ERROR_INJECT_EN.
module tb_axis_row_producer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [63:0]  row_count;
    logic         busy, done;
    logic [63:0]  rows_sent;
    logic [511:0] AXIS_OUT_TDATA;
    logic         AXIS_OUT_TVALID;
    logic         AXIS_OUT_TREADY;
    logic [71:0]  AXI_REQ_IN_TDATA;
    logic         AXI_REQ_IN_TVALID;
    logic         AXI_REQ_IN_TREADY;
`ifdef AXIS_ROW_PRODUCER_ERROR_INJECT_EN
    logic         inject_error;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [511:0] got_q[$];
    logic [511:0] exp_q[$];
    int           stall_errs, req_hs, rdy_in_row;

    always #5 clk = ~clk;

    axis_row_producer #(.DATA_WIDTH(512), .DATA_CYCLES(32)) dut (
        .clk               (clk),
        .reset             (reset),
`ifdef AXIS_ROW_PRODUCER_ERROR_INJECT_EN
        .inject_error      (inject_error),
`endif
        .start             (start),
        .row_count         (row_count),
        .busy              (busy),
        .done              (done),
        .rows_sent         (rows_sent),
        .AXIS_OUT_TDATA    (AXIS_OUT_TDATA),
        .AXIS_OUT_TVALID   (AXIS_OUT_TVALID),
        .AXIS_OUT_TREADY   (AXIS_OUT_TREADY),
        .AXI_REQ_IN_TDATA  (AXI_REQ_IN_TDATA),
        .AXI_REQ_IN_TVALID (AXI_REQ_IN_TVALID),
        .AXI_REQ_IN_TREADY (AXI_REQ_IN_TREADY)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [511:0] row_beat(input logic [63:0] idx);
        logic [511:0] b;
        b = '0;
        b[63:0] = idx;
        return b;
    endfunction

    function automatic logic [511:0] data_beat(input logic [31:0] s);
        logic [511:0] b;
        logic [31:0]  p;
        for (int w = 0; w < 16; w++) begin
            case (w % 4)
                0:       p = 32'h0000_0000;
                1:       p = 32'hFFFF_FFFF;
                2:       p = 32'hAAAA_AAAA;
                default: p = 32'h5555_5555;
            endcase
            b[32*w +: 32] = s ^ p;
        end
        return b;
    endfunction

    function automatic logic [511:0] req_beat(input logic [31:0] a, input logic [31:0] d, input logic m);
        logic [511:0] b;
        b = '0;
        b[511:504] = 8'd1;
        b[31:0]    = a;
        b[63:32]   = d;
        b[64]      = m;
        return b;
    endfunction

    task automatic build_exp(input int rows, input int req_after_row, input logic [511:0] rb);
        logic [31:0] s;
        s = 0;
        exp_q.delete();
        for (int r = 0; r < rows; r++) begin
            exp_q.push_back(row_beat(64'(r)));
            for (int k = 0; k < 32; k++) begin
                exp_q.push_back(data_beat(s));
                s++;
            end
            exp_q.push_back(row_beat(64'(r)));
            if (r == req_after_row) exp_q.push_back(rb);
        end
    endtask

    // Consumer model: records accepted beats until done, optionally injecting a request
    // after req_at beats and an error-inject sequence after inj_at beats.
    task automatic collect(input int max_cycles, input bit rnd, input int req_at,
                           input int inj_at, output bit got_done);
        bit           prev_stall, drop_req, req_sent;
        logic [511:0] prev_data;
        int           inj_ph;
        prev_stall = 0; drop_req = 0; req_sent = 0; prev_data = '0; inj_ph = 0;
        got_done = 0; stall_errs = 0; req_hs = 0; rdy_in_row = 0;
        got_q.delete();
        for (int c = 0; c < max_cycles; c++) begin
            AXIS_OUT_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
`ifdef AXIS_ROW_PRODUCER_ERROR_INJECT_EN
            inject_error = 1'b0;
            if (inj_at >= 0 && inj_ph < 5 && got_q.size() >= inj_at) begin
                if (inj_ph < 4) AXIS_OUT_TREADY = 1'b0;
                inject_error = (inj_ph == 1 || inj_ph == 3);
                inj_ph++;
            end
`else
            inj_ph = inj_at;
`endif
            if (req_at >= 0 && !req_sent && got_q.size() >= req_at) AXI_REQ_IN_TVALID = 1'b1;
            if (prev_stall && (!AXIS_OUT_TVALID || AXIS_OUT_TDATA !== prev_data)) stall_errs++;
            if (AXI_REQ_IN_TREADY && AXIS_OUT_TVALID) rdy_in_row++;
            if (AXI_REQ_IN_TVALID && AXI_REQ_IN_TREADY) begin
                req_hs++;
                drop_req = 1;
            end
            if (AXIS_OUT_TVALID && AXIS_OUT_TREADY) got_q.push_back(AXIS_OUT_TDATA);
            prev_stall = AXIS_OUT_TVALID && !AXIS_OUT_TREADY;
            prev_data  = AXIS_OUT_TDATA;
            if (done) begin
                got_done = 1;
                break;
            end
            step();
            if (drop_req) begin
                AXI_REQ_IN_TVALID = 1'b0;
                req_sent = 1;
                drop_req = 0;
            end
        end
`ifdef AXIS_ROW_PRODUCER_ERROR_INJECT_EN
        inject_error = 1'b0;
`endif
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, "_len"}, 512'(got_q.size()), 512'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        bit           d;
        logic [511:0] rq;
        reset = 1'b1; start = 1'b0; row_count = '0; AXIS_OUT_TREADY = 1'b0;
        AXI_REQ_IN_TDATA = '0; AXI_REQ_IN_TVALID = 1'b0;
`ifdef AXIS_ROW_PRODUCER_ERROR_INJECT_EN
        inject_error = 1'b0;
`endif
        step(); step();
        chk("rst_tvalid",    512'(AXIS_OUT_TVALID),   512'd0);
        chk("rst_busy",      512'(busy),              512'd0);
        chk("rst_done",      512'(done),              512'd0);
        chk("rst_rows_sent", 512'(rows_sent),         512'd0);
        chk("rst_req_ready", 512'(AXI_REQ_IN_TREADY), 512'd0);
        reset = 1'b0;
        step();

        // 1: single row, consumer always ready
        row_count = 64'd1; start = 1'b1; AXIS_OUT_TREADY = 1'b1;
        step();
        start = 1'b0;
        chk("t1_latency", 512'(AXIS_OUT_TVALID), 512'd1);
        chk("t1_header",  AXIS_OUT_TDATA, row_beat(64'd0));
        chk("t1_busy",    512'(busy), 512'd1);
        collect(300, 0, -1, -1, d);
        chk("t1_done", 512'(d), 512'd1);
        build_exp(1, -1, '0);
        compare_stream("t1");
        chk("t1_rows_sent", 512'(rows_sent), 512'd1);
        chk("t1_busy_end",  512'(busy), 512'd0);
        step();
        chk("t1_done_pulse", 512'(done), 512'd0);

        // 2: three rows, random back-pressure
        row_count = 64'd3; start = 1'b1;
        step();
        start = 1'b0;
        collect(3000, 1, -1, -1, d);
        chk("t2_done", 512'(d), 512'd1);
        build_exp(3, -1, '0);
        compare_stream("t2");
        chk("t2_stall_stable", 512'(stall_errs), 512'd0);
        chk("t2_rows_sent",    512'(rows_sent), 512'd3);

        // 3: request raised mid-row 0 of 2
        AXI_REQ_IN_TDATA = '0;
        AXI_REQ_IN_TDATA[31:0]  = 32'h0000_1000;
        AXI_REQ_IN_TDATA[63:32] = 32'hDEAD_BEEF;
        AXI_REQ_IN_TDATA[64]    = 1'b1;
        row_count = 64'd2; start = 1'b1; AXIS_OUT_TREADY = 1'b1;
        step();
        start = 1'b0;
        collect(600, 0, 10, -1, d);
        chk("t3_done", 512'(d), 512'd1);
        rq = req_beat(32'h0000_1000, 32'hDEAD_BEEF, 1'b1);
        build_exp(2, 0, rq);
        compare_stream("t3");
        chk("t3_req_handshakes", 512'(req_hs), 512'd1);
        chk("t3_ready_in_row",   512'(rdy_in_row), 512'd0);

        // 4: empty dataset
        row_count = 64'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_done",   512'(done), 512'd1);
        chk("t4_busy",   512'(busy), 512'd0);
        chk("t4_tvalid", 512'(AXIS_OUT_TVALID), 512'd0);
        step();
        chk("t4_done_pulse", 512'(done), 512'd0);
        chk("t4_busy2",      512'(busy), 512'd0);
        chk("t4_tvalid2",    512'(AXIS_OUT_TVALID), 512'd0);

        // 5: reset on the 10th data beat, then restart from seed 0
        row_count = 64'd2; start = 1'b1; AXIS_OUT_TREADY = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("t5_beat10", AXIS_OUT_TDATA, data_beat(32'd9));
        reset = 1'b1;
        step();
        chk("t5_tvalid",    512'(AXIS_OUT_TVALID), 512'd0);
        chk("t5_busy",      512'(busy), 512'd0);
        chk("t5_rows_sent", 512'(rows_sent), 512'd0);
        reset = 1'b0;
        step();
        row_count = 64'd1; start = 1'b1;
        step();
        start = 1'b0;
        collect(300, 0, -1, -1, d);
        chk("t5_done", 512'(d), 512'd1);
        build_exp(1, -1, '0);
        compare_stream("t5");

`ifdef AXIS_ROW_PRODUCER_ERROR_INJECT_EN
        // 6: two inject pulses during a stall in row 0 flip exactly one data beat
        begin
            int           errs, bad;
            logic [511:0] mask;
            mask = 512'd1;
            mask = mask << 32;
            errs = 0; bad = 0;
            row_count = 64'd1; start = 1'b1;
            step();
            start = 1'b0;
            collect(300, 0, -1, 5, d);
            chk("t6_done", 512'(d), 512'd1);
            build_exp(1, -1, '0);
            chk("t6_len", 512'(got_q.size()), 512'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                if (got_q[i] !== exp_q[i]) begin
                    errs++;
                    if ((got_q[i] ^ exp_q[i]) !== mask) bad++;
                end
            end
            chk("t6_err_count", 512'(errs), 512'd1);
            chk("t6_err_bit",   512'(bad),  512'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
